// File: rtl/chess_pkg.sv
// chess_pkg -- definitions shared by the chess display path (board_state,
// board_move_check, screen_gen).
//   piece_t   : 4-bit piece code. 0..5 are white P N B R Q K, 6..11 are the
//               same pieces for black, and any code >= 12 is an empty square.
//   square_t  : 6-bit square index {row[5:3], col[2:0]}.
//   board_t   : packed 8x8 piece map, indexed board[row][col].
//   state_t   : move sequencer FSM states.
//   START_POS : the start position. Black is on rows 0/1, white on rows 6/7.
package chess_pkg;

  typedef logic [3:0] piece_t;
  typedef logic [5:0] square_t;
  typedef piece_t [7:0][7:0] board_t;

  localparam piece_t W_PAWN   = 4'd0;
  localparam piece_t W_KNIGHT = 4'd1;
  localparam piece_t W_BISHOP = 4'd2;
  localparam piece_t W_ROOK   = 4'd3;
  localparam piece_t W_QUEEN  = 4'd4;
  localparam piece_t W_KING   = 4'd5;
  localparam piece_t B_PAWN   = 4'd6;
  localparam piece_t B_KNIGHT = 4'd7;
  localparam piece_t B_BISHOP = 4'd8;
  localparam piece_t B_ROOK   = 4'd9;
  localparam piece_t B_QUEEN  = 4'd10;
  localparam piece_t B_KING   = 4'd11;

  // The canonical empty code. Every code from FIRST_EMPTY upward also
  // counts as empty.
  localparam piece_t EMPTY_CODE  = 4'hF;
  localparam piece_t FIRST_EMPTY = 4'd12;
  localparam piece_t BLACK_BASE  = 4'd6;

  typedef enum logic [2:0] {
    IDLE,
    INIT_WAIT,
    MV_WAIT,
    CHECK,
    APPLY,
    DONE
  } state_t;

  function automatic logic is_empty(piece_t p);
    return p >= FIRST_EMPTY;
  endfunction

  // Only meaningful for an occupied square.
  function automatic logic is_black(piece_t p);
    return p >= BLACK_BASE;
  endfunction

  // White back rank, ordered from column 0 to column 7. The black back
  // rank uses the same order with BLACK_BASE added to each code.
  function automatic piece_t back_rank(logic [2:0] col);
    piece_t p;
    case (col)
      3'd0, 3'd7: p = W_ROOK;
      3'd1, 3'd6: p = W_KNIGHT;
      3'd2, 3'd5: p = W_BISHOP;
      3'd3:       p = W_QUEEN;
      default:    p = W_KING;
    endcase
    return p;
  endfunction

  function automatic board_t start_position();
    board_t b;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        b[3'(r)][3'(c)] = EMPTY_CODE;
      end
    end
    for (int c = 0; c < 8; c++) begin
      b[3'd0][3'(c)] = back_rank(3'(c)) + BLACK_BASE;
      b[3'd1][3'(c)] = B_PAWN;
      b[3'd6][3'(c)] = W_PAWN;
      b[3'd7][3'(c)] = back_rank(3'(c));
    end
    return b;
  endfunction

  localparam board_t START_POS = start_position();

endpackage

// File: rtl/board_state_if.sv
// board_state_if -- move and new-game handshake between the game controller
// (master) and board_state (slave).
//   new_game : level request to reload the start position
//   mv_valid : move request valid
//   mv_ready : board_state can accept a move
//   mv_from  : source square {row, col}
//   mv_to    : destination square {row, col}
//   mv_done  : one-cycle pulse when a move request completes
//   mv_err   : qualifies mv_done; the move was rejected and the board is unchanged
interface board_state_if;
  import chess_pkg::*;

  logic    new_game;
  logic    mv_valid;
  logic    mv_ready;
  square_t mv_from;
  square_t mv_to;
  logic    mv_done;
  logic    mv_err;

  modport master (
    output new_game, mv_valid, mv_from, mv_to,
    input  mv_ready, mv_done, mv_err
  );

  modport slave (
    input  new_game, mv_valid, mv_from, mv_to,
    output mv_ready, mv_done, mv_err
  );

endinterface

// File: rtl/board_move_check.sv
// board_move_check -- combinational accept/reject decision for a single move.
//   src_piece    : piece on the source square
//   dst_piece    : piece on the destination square
//   same_square  : source and destination are the same square
//   side_to_move : 0 = white, 1 = black
//   reject       : the move breaks an occupancy or colour rule
//   capture      : the destination is occupied. This port exists only when
//                  BOARD_CAPTURE_TRACK_EN is defined.
// Chess legality is the game controller's job. Only the occupancy and colour
// rules are checked here.
module board_move_check
  import chess_pkg::*;
(
  input  piece_t src_piece,
  input  piece_t dst_piece,
  input  logic   same_square,
  input  logic   side_to_move,
  output logic   reject
`ifdef BOARD_CAPTURE_TRACK_EN
  ,
  output logic   capture
`endif
);

  // A move is rejected if any of these hold: the source is empty, the move
  // does not change square, the mover belongs to the wrong side, or the
  // destination holds one of the mover's own pieces.
  always_comb begin
    reject = is_empty(src_piece)
           | same_square
           | (is_black(src_piece) != side_to_move)
           | (!is_empty(dst_piece) && (is_black(dst_piece) == side_to_move));
  end

`ifdef BOARD_CAPTURE_TRACK_EN
  // An accepted move onto an occupied square can only land on an
  // opposing piece, so occupancy alone marks a capture.
  always_comb begin
    capture = !is_empty(dst_piece);
  end
`endif

endmodule

// File: rtl/board_state.sv
// board_state -- authoritative 8x8 piece map and move sequencer for the chess
// display path. Every board update is committed during vertical blanking, so
// a frame never shows a half-applied move.
//   vga_clk      : single clock
//   reset_n      : synchronous, active-low reset
//   vcount       : current VGA line. Blanking is vcount >= SCREEN_HEIGHT.
//   mv           : board_state_if.slave, the move and new-game handshake
//   side_to_move : 0 = white, 1 = black
//   move_count   : count of accepted moves, saturating at 1023
//   board        : registered piece map, board[row][col]
//   white_caps / black_caps : capture counters, saturating at 15
// Optional feature: define BOARD_CAPTURE_TRACK_EN to build the capture
// counters. Without it both counters are tied to zero.
module board_state
  import chess_pkg::*;
#(
  parameter int unsigned SCREEN_HEIGHT = 480
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  input  logic [9:0]         vcount,
  board_state_if.slave       mv,
  output logic               side_to_move,
  output logic [9:0]         move_count,
  output board_t             board,
  output logic [3:0]         white_caps,
  output logic [3:0]         black_caps
);

  localparam logic [9:0] BLANK_LINE = 10'(SCREEN_HEIGHT);

  state_t  state, state_next;
  square_t from_q, to_q;
  logic    err_q;
  logic    blank;
  logic    accept;
  logic    init_load;
  logic    reject;
  piece_t  src_piece, dst_piece;

  assign blank     = vcount >= BLANK_LINE;
  assign accept    = mv.mv_ready & mv.mv_valid;
  assign init_load = (state == INIT_WAIT) && blank;
  assign src_piece = board[from_q[5:3]][from_q[2:0]];
  assign dst_piece = board[to_q[5:3]][to_q[2:0]];

`ifdef BOARD_CAPTURE_TRACK_EN
  logic capture;
`endif

  board_move_check u_move_check (
    .src_piece    (src_piece),
    .dst_piece    (dst_piece),
    .same_square  (from_q == to_q),
    .side_to_move (side_to_move),
    .reject       (reject)
`ifdef BOARD_CAPTURE_TRACK_EN
    ,
    .capture      (capture)
`endif
  );

  // Next-state and handshake outputs. new_game takes priority in IDLE and
  // drops mv_ready in the same cycle, so a move presented together with it
  // is never accepted.
  always_comb begin
    state_next  = state;
    mv.mv_ready = 1'b0;
    mv.mv_done  = 1'b0;
    mv.mv_err   = 1'b0;
    unique case (state)
      IDLE: begin
        if (mv.new_game) begin
          state_next = INIT_WAIT;
        end else begin
          mv.mv_ready = 1'b1;
          if (mv.mv_valid) state_next = MV_WAIT;
        end
      end
      INIT_WAIT: if (blank) state_next = IDLE;
      MV_WAIT:   if (blank) state_next = CHECK;
      CHECK:     state_next = reject ? DONE : APPLY;
      APPLY:     state_next = DONE;
      DONE: begin
        mv.mv_done = 1'b1;
        mv.mv_err  = err_q;
        state_next = IDLE;
      end
      default:   state_next = IDLE;
    endcase
  end

  // State register, latched request, and the board itself. The board is
  // written only in INIT_WAIT and APPLY, and both are reached only during
  // blanking. CHECK and APPLY each take one cycle, so a write always lands
  // inside the blank.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      from_q       <= '0;
      to_q         <= '0;
      err_q        <= 1'b0;
      board        <= START_POS;
      side_to_move <= 1'b0;
      move_count   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        from_q <= mv.mv_from;
        to_q   <= mv.mv_to;
      end
      if (state == CHECK) err_q <= reject;
      if (init_load) begin
        board        <= START_POS;
        side_to_move <= 1'b0;
        move_count   <= '0;
      end
      if (state == APPLY) begin
        board[to_q[5:3]][to_q[2:0]]     <= src_piece;
        board[from_q[5:3]][from_q[2:0]] <= EMPTY_CODE;
        side_to_move                    <= ~side_to_move;
        if (move_count != 10'h3FF) move_count <= move_count + 10'd1;
      end
    end
  end

`ifdef BOARD_CAPTURE_TRACK_EN
  // Capture counters are credited to the side that made the capture and
  // saturate at 15. A new game clears them.
  always_ff @(posedge vga_clk) begin
    if (!reset_n || init_load) begin
      white_caps <= '0;
      black_caps <= '0;
    end else if ((state == APPLY) && capture) begin
      if (!side_to_move) begin
        if (white_caps != 4'hF) white_caps <= white_caps + 4'd1;
      end else begin
        if (black_caps != 4'hF) black_caps <= black_caps + 4'd1;
      end
    end
  end
`else
  assign white_caps = 4'd0;
  assign black_caps = 4'd0;
`endif

endmodule

// File: tb/tb_board_state.sv
// tb_board_state -- self-checking bench for board_state. It runs a move
// table from a known position, plus hand-written sequences for the
// active-region wait, a new game raised together with a move, and a reset
// in the middle of a move. Square literals are written in octal, so 6'o64
// means row 6, column 4.
module tb_board_state;
  import chess_pkg::*;

  localparam int WAIT_LIMIT = 2000;

  logic       vga_clk = 1'b0;
  logic       reset_n;
  logic [9:0] vcount;
  logic       side_to_move;
  logic [9:0] move_count;
  board_t     board;
  logic [3:0] white_caps;
  logic [3:0] black_caps;

  board_state_if mv_bus ();

  board_state dut (
    .vga_clk      (vga_clk),
    .reset_n      (reset_n),
    .vcount       (vcount),
    .mv           (mv_bus),
    .side_to_move (side_to_move),
    .move_count   (move_count),
    .board        (board),
    .white_caps   (white_caps),
    .black_caps   (black_caps)
  );

  // 100 MHz-style free-running clock
  always #5 vga_clk = ~vga_clk;

  typedef struct {
    logic [5:0] from_sq;
    logic [5:0] to_sq;
    logic       exp_err;
    logic [5:0] sq_a;
    logic [3:0] exp_a;
    logic [5:0] sq_b;
    logic [3:0] exp_b;
    logic       exp_side;
    logic [9:0] exp_count;
    logic [3:0] exp_wc;
    logic [3:0] exp_bc;
  } vec_t;

  vec_t       vecs [10];
  logic [3:0] exp_start [64];
  int         checks   = 0;
  int         failures = 0;

  function automatic logic [3:0] getSq(logic [5:0] sq);
    return board[sq[5:3]][sq[2:0]];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic checkBoard(input string name);
    logic [5:0] sq;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        sq = {3'(r), 3'(c)};
        checkOutput($sformatf("%s_sq%0o", name, sq), 32'(getSq(sq)), 32'(exp_start[sq]));
      end
    end
  endtask

  // Present a move, let it be accepted, then drop mv_valid.
  task automatic issueMove(input logic [5:0] from_sq, input logic [5:0] to_sq);
    @(negedge vga_clk);
    mv_bus.mv_valid = 1'b1;
    mv_bus.mv_from  = from_sq;
    mv_bus.mv_to    = to_sq;
    #1 checkOutput("ready_before_accept", 32'(mv_bus.mv_ready), 32'd1);
    @(posedge vga_clk);
    @(negedge vga_clk);
    mv_bus.mv_valid = 1'b0;
    checkOutput("ready_after_accept", 32'(mv_bus.mv_ready), 32'd0);
  endtask

  // Count clock edges until mv_done, with a bounded wait.
  task automatic waitDone(output int lat, output logic err);
    lat = 0;
    while (mv_bus.mv_done !== 1'b1 && lat < WAIT_LIMIT) begin
      @(negedge vga_clk);
      lat++;
    end
    err = mv_bus.mv_err;
    checkOutput("ready_in_done", 32'(mv_bus.mv_ready), 32'd0);
  endtask

  task automatic applyStimulus(input logic [5:0] from_sq, input logic [5:0] to_sq,
                               output int lat, output logic err);
    issueMove(from_sq, to_sq);
    waitDone(lat, err);
  endtask

  initial begin
    int         lat;
    logic       err;
    logic       seen_done;
    logic [3:0] exp_wc, exp_bc;
    logic [3:0] black_back [8];
    logic [3:0] white_back [8];

    black_back = '{4'd9, 4'd7, 4'd8, 4'd10, 4'd11, 4'd8, 4'd7, 4'd9};
    white_back = '{4'd3, 4'd1, 4'd2, 4'd4, 4'd5, 4'd2, 4'd1, 4'd3};
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        case (r)
          0:       exp_start[{3'(r), 3'(c)}] = black_back[3'(c)];
          1:       exp_start[{3'(r), 3'(c)}] = 4'd6;
          6:       exp_start[{3'(r), 3'(c)}] = 4'd0;
          7:       exp_start[{3'(r), 3'(c)}] = white_back[3'(c)];
          default: exp_start[{3'(r), 3'(c)}] = 4'hF;
        endcase
      end
    end

    // The table starts after white e-pawn 64->44, with black to move.
    //          from    to     err   sq_a   a      sq_b   b      side  cnt    wc    bc
    vecs[0] = '{6'o70, 6'o50, 1'b1, 6'o70, 4'd3, 6'o50, 4'hF, 1'b1, 10'd1, 4'd0, 4'd0};
    vecs[1] = '{6'o13, 6'o33, 1'b0, 6'o33, 4'd6, 6'o13, 4'hF, 1'b0, 10'd2, 4'd0, 4'd0};
    vecs[2] = '{6'o44, 6'o33, 1'b0, 6'o33, 4'd0, 6'o44, 4'hF, 1'b1, 10'd3, 4'd1, 4'd0};
    vecs[3] = '{6'o00, 6'o00, 1'b1, 6'o00, 4'd9, 6'o01, 4'd7, 1'b1, 10'd3, 4'd1, 4'd0};
    vecs[4] = '{6'o33, 6'o22, 1'b1, 6'o33, 4'd0, 6'o22, 4'hF, 1'b1, 10'd3, 4'd1, 4'd0};
    vecs[5] = '{6'o00, 6'o01, 1'b1, 6'o00, 4'd9, 6'o01, 4'd7, 1'b1, 10'd3, 4'd1, 4'd0};
    vecs[6] = '{6'o40, 6'o30, 1'b1, 6'o40, 4'hF, 6'o30, 4'hF, 1'b1, 10'd3, 4'd1, 4'd0};
    vecs[7] = '{6'o01, 6'o60, 1'b0, 6'o60, 4'd7, 6'o01, 4'hF, 1'b0, 10'd4, 4'd1, 4'd1};
    vecs[8] = '{6'o73, 6'o04, 1'b0, 6'o04, 4'd4, 6'o73, 4'hF, 1'b1, 10'd5, 4'd2, 4'd1};
    vecs[9] = '{6'o10, 6'o77, 1'b0, 6'o77, 4'd6, 6'o10, 4'hF, 1'b0, 10'd6, 4'd2, 4'd2};

    reset_n         = 1'b0;
    vcount          = 10'd480;
    mv_bus.new_game = 1'b0;
    mv_bus.mv_valid = 1'b0;
    mv_bus.mv_from  = '0;
    mv_bus.mv_to    = '0;
    repeat (2) @(posedge vga_clk);
    @(negedge vga_clk);
    reset_n = 1'b1;

    $display("[TB] reset state");
    checkBoard("reset");
    checkOutput("reset_ready", 32'(mv_bus.mv_ready), 32'd1);
    checkOutput("reset_done",  32'(mv_bus.mv_done),  32'd0);
    checkOutput("reset_err",   32'(mv_bus.mv_err),   32'd0);
    checkOutput("reset_side",  32'(side_to_move),    32'd0);
    checkOutput("reset_count", 32'(move_count),      32'd0);
    checkOutput("reset_wcaps", 32'(white_caps),      32'd0);
    checkOutput("reset_bcaps", 32'(black_caps),      32'd0);

    $display("[TB] move held off until blanking");
    vcount = 10'd100;
    issueMove(6'o64, 6'o44);
    seen_done = 1'b0;
    repeat (10) begin
      @(negedge vga_clk);
      if (mv_bus.mv_done === 1'b1) seen_done = 1'b1;
    end
    checkOutput("active_no_done",   32'(seen_done),       32'd0);
    checkOutput("active_ready_low", 32'(mv_bus.mv_ready), 32'd0);
    vcount = 10'd480;
    waitDone(lat, err);
    checkOutput("first_latency", 32'(lat), 32'd3);
    checkOutput("first_err",     32'(err), 32'd0);
    @(negedge vga_clk);
    checkOutput("first_done_one_cycle", 32'(mv_bus.mv_done),  32'd0);
    checkOutput("first_ready_back",     32'(mv_bus.mv_ready), 32'd1);
    checkOutput("first_dst",   32'(getSq(6'o44)), 32'd0);
    checkOutput("first_src",   32'(getSq(6'o64)), 32'hF);
    checkOutput("first_side",  32'(side_to_move), 32'd1);
    checkOutput("first_count", 32'(move_count),   32'd1);

    $display("[TB] move table");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].from_sq, vecs[i].to_sq, lat, err);
      checkOutput($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      checkOutput($sformatf("v%0d_latency", i), 32'(lat), vecs[i].exp_err ? 32'd2 : 32'd3);
      @(negedge vga_clk);
`ifdef BOARD_CAPTURE_TRACK_EN
      exp_wc = vecs[i].exp_wc;
      exp_bc = vecs[i].exp_bc;
`else
      exp_wc = 4'd0;
      exp_bc = 4'd0;
`endif
      checkOutput($sformatf("v%0d_done_low", i), 32'(mv_bus.mv_done), 32'd0);
      checkOutput($sformatf("v%0d_sq_a", i), 32'(getSq(vecs[i].sq_a)), 32'(vecs[i].exp_a));
      checkOutput($sformatf("v%0d_sq_b", i), 32'(getSq(vecs[i].sq_b)), 32'(vecs[i].exp_b));
      checkOutput($sformatf("v%0d_side", i), 32'(side_to_move), 32'(vecs[i].exp_side));
      checkOutput($sformatf("v%0d_count", i), 32'(move_count), 32'(vecs[i].exp_count));
      checkOutput($sformatf("v%0d_wcaps", i), 32'(white_caps), 32'(exp_wc));
      checkOutput($sformatf("v%0d_bcaps", i), 32'(black_caps), 32'(exp_bc));
    end

    $display("[TB] new_game together with mv_valid");
    vcount = 10'd100;
    @(negedge vga_clk);
    mv_bus.new_game = 1'b1;
    mv_bus.mv_valid = 1'b1;
    mv_bus.mv_from  = 6'o63;
    mv_bus.mv_to    = 6'o53;
    #1 checkOutput("ng_ready_low", 32'(mv_bus.mv_ready), 32'd0);
    @(posedge vga_clk);
    @(negedge vga_clk);
    mv_bus.new_game = 1'b0;
    mv_bus.mv_valid = 1'b0;
    seen_done = 1'b0;
    repeat (5) begin
      @(negedge vga_clk);
      if (mv_bus.mv_done === 1'b1) seen_done = 1'b1;
    end
    checkOutput("ng_held_in_active", 32'(getSq(6'o77)), 32'd6);
    vcount = 10'd480;
    repeat (3) begin
      @(negedge vga_clk);
      if (mv_bus.mv_done === 1'b1) seen_done = 1'b1;
    end
    checkOutput("ng_no_done", 32'(seen_done), 32'd0);
    checkBoard("newgame");
    checkOutput("ng_side",  32'(side_to_move),    32'd0);
    checkOutput("ng_count", 32'(move_count),      32'd0);
    checkOutput("ng_wcaps", 32'(white_caps),      32'd0);
    checkOutput("ng_bcaps", 32'(black_caps),      32'd0);
    checkOutput("ng_ready", 32'(mv_bus.mv_ready), 32'd1);

    $display("[TB] reset while a move waits for blanking");
    applyStimulus(6'o63, 6'o53, lat, err);
    checkOutput("pre_reset_err", 32'(err), 32'd0);
    @(negedge vga_clk);
    checkOutput("pre_reset_dst", 32'(getSq(6'o53)), 32'd0);
    vcount = 10'd100;
    issueMove(6'o13, 6'o23);
    seen_done = 1'b0;
    repeat (2) begin
      @(negedge vga_clk);
      if (mv_bus.mv_done === 1'b1) seen_done = 1'b1;
    end
    reset_n = 1'b0;
    @(posedge vga_clk);
    @(negedge vga_clk);
    reset_n = 1'b1;
    vcount  = 10'd480;
    repeat (6) begin
      @(negedge vga_clk);
      if (mv_bus.mv_done === 1'b1) seen_done = 1'b1;
    end
    checkOutput("midreset_no_done", 32'(seen_done), 32'd0);
    checkBoard("midreset");
    checkOutput("midreset_side",  32'(side_to_move),    32'd0);
    checkOutput("midreset_count", 32'(move_count),      32'd0);
    checkOutput("midreset_ready", 32'(mv_bus.mv_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
